uart_receiver: RTL and testbench

Serial-to-parallel UART receive stage, the line-side counterpart to the team's uart_transmitter. It consumes the serial stream the transmitter produces (idle-high, 1 start bit, UART_BITS_TRANSFERED data bits LSB-first, 1 stop bit). It samples each bit once at mid-period. It delivers each received word as a parallel message with a one-cycle valid pulse, and flags frames whose stop bit is low.

---
 rtl/uart_receiver.sv | 142 ++++++++++++++
 tb/tb_uart_receiver.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
// UART receive stage: synchronizes rx, finds the start edge, samples each bit once at mid-period,
// and presents the received word with a one-cycle valid pulse or a one-cycle framing_error pulse.
module uart_receiver #(
    parameter int UART_BITS_TRANSFERED = 8,
    parameter int CYCLES_PER_BIT       = 17,
    parameter int SYNC_STAGES          = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            rx,
    output logic [UART_BITS_TRANSFERED-1:0] message,
    output logic                            valid,
    output logic                            framing_error,
    output logic                            busy
);

    localparam int HALF  = CYCLES_PER_BIT / 2;
    localparam int CNT_W = $clog2(CYCLES_PER_BIT);
    localparam int IDX_W = (UART_BITS_TRANSFERED > 1) ? $clog2(UART_BITS_TRANSFERED) : 1;

    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] CNT_BIT  = CNT_W'(CYCLES_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(UART_BITS_TRANSFERED - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t                          state_q, state_d;
    logic [SYNC_STAGES-1:0]          sync_q, sync_d;
    logic [CNT_W-1:0]                cnt_q, cnt_d;
    logic [IDX_W-1:0]                idx_q, idx_d;
    logic [UART_BITS_TRANSFERED-1:0] shift_q, shift_d;
    logic [UART_BITS_TRANSFERED-1:0] message_q, message_d;
    logic                            valid_q, valid_d;
    logic                            ferr_q, ferr_d;
    logic                            rx_s;

    assign rx_s          = sync_q[SYNC_STAGES-1];
    assign message       = message_q;
    assign valid         = valid_q;
    assign framing_error = ferr_q;
    assign busy          = (state_q != S_IDLE);

    // Synchronizer resets to all ones so the line reads idle coming out of reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            sync_q    <= '1;
            cnt_q     <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            message_q <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sync_q    <= sync_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            message_q <= message_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        sync_d    = {sync_q[SYNC_STAGES-2:0], rx};
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        message_d = message_q;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!rx_s) begin
                    cnt_d   = CNT_HALF;
                    state_d = S_START;
                end
            end
            // Start bit is re-checked at its midpoint to reject glitches
            S_START: begin
                if (cnt_q == '0) begin
                    if (!rx_s) begin
                        state_d = S_DATA;
                        cnt_d   = CNT_BIT;
                        idx_d   = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_DATA: begin
                if (cnt_q == '0) begin
                    shift_d[idx_q] = rx_s;
                    cnt_d          = CNT_BIT;
                    if (idx_q == IDX_LAST) begin
                        state_d = S_STOP;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            // Leaving mid stop bit leaves half a bit of margin for a back-to-back start edge
            S_STOP: begin
                if (cnt_q == '0) begin
                    if (rx_s) begin
                        message_d = shift_q;
                        valid_d   = 1'b1;
                        state_d   = S_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = S_BREAK;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_BREAK: begin
                if (rx_s) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Directed and randomized bench for uart_receiver: frames are bit-banged on rx and delivered
// words are checked against a queue of words that a correct receiver must produce.
module tb_uart_receiver;

    localparam int NB  = 8;
    localparam int CPB = 17;

    logic          clk;
    logic          rst;
    logic          rx;
    logic [NB-1:0] message;
    logic          valid;
    logic          framing_error;
    logic          busy;

    int            total;
    int            bad;
    int            got_valid;
    int            fe_cnt;
    bit            busy_seen;
    bit            prev_v;
    bit            prev_f;
    logic [NB-1:0] model_msg;
    logic [NB-1:0] exp_q[$];

    uart_receiver #(
        .UART_BITS_TRANSFERED(NB),
        .CYCLES_PER_BIT(CPB),
        .SYNC_STAGES(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rx(rx),
        .message(message),
        .valid(valid),
        .framing_error(framing_error),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Output monitor, sampled on the inactive edge
    always @(negedge clk) begin
        if (valid) begin
            got_valid++;
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 32'(message), 32'hFFFF_FFFF);
            end else begin
                model_msg = exp_q.pop_front();
                check("message", 32'(message), 32'(model_msg));
            end
        end
        if (framing_error) fe_cnt++;
        if (valid || framing_error) begin
            check("pulse_exclusive", 32'(valid && framing_error), 32'd0);
            check("pulse_width", 32'((valid && prev_v) || (framing_error && prev_f)), 32'd0);
        end
        if (busy) busy_seen = 1'b1;
        prev_v = valid;
        prev_f = framing_error;
    end

    task automatic hold(input logic level, input int n);
        rx = level;
        repeat (n) @(negedge clk);
    endtask

    // Frame with optional edge jitter: every edge moves by up to +/-3 cycles from nominal
    task automatic send_frame(input logic [NB-1:0] d, input logic stop, input bit jit);
        int off[NB+3];
        logic lvl;
        for (int k = 0; k < NB + 3; k++) off[k] = 0;
        if (jit) for (int k = 1; k <= NB + 1; k++) off[k] = int'($urandom_range(0, 6)) - 3;
        for (int k = 0; k <= NB + 1; k++) begin
            if (k == 0) lvl = 1'b0;
            else if (k <= NB) lvl = d[k-1];
            else lvl = stop;
            hold(lvl, CPB + off[k+1] - off[k]);
        end
        rx = 1'b1;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(negedge clk);
        check(tag, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int v0;
        int f0;
        logic [NB-1:0] d;
        total = 0; bad = 0; got_valid = 0; fe_cnt = 0;
        busy_seen = 1'b0; prev_v = 1'b0; prev_f = 1'b0;
        model_msg = '0;
        rx = 1'b1;
        rst = 1'b1;
        repeat (4) @(negedge clk);
        check("reset_message", 32'(message), 32'd0);
        check("reset_valid", 32'(valid), 32'd0);
        check("reset_ferr", 32'(framing_error), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        hold(1'b1, 5);

        // Single clean frame
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1, 1'b0);
        drain("drain_a5");
        hold(1'b1, 10);
        check("a5_valid_count", 32'(got_valid), 32'd1);
        check("a5_message", 32'(message), 32'hA5);
        check("a5_busy_after", 32'(busy), 32'd0);
        check("a5_no_ferr", 32'(fe_cnt), 32'd0);

        // Back-to-back frames with zero idle gap
        exp_q.push_back(8'h00); exp_q.push_back(8'hFF); exp_q.push_back(8'h3C);
        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        send_frame(8'h3C, 1'b1, 1'b0);
        drain("drain_b2b");
        hold(1'b1, 10);
        check("b2b_valid_count", 32'(got_valid), 32'd4);
        check("b2b_message", 32'(message), 32'h3C);

        // Short glitch is a false start
        v0 = got_valid; f0 = fe_cnt; busy_seen = 1'b0;
        hold(1'b0, 3);
        hold(1'b1, 25);
        check("glitch_busy_seen", 32'(busy_seen), 32'd1);
        check("glitch_busy_low", 32'(busy), 32'd0);
        check("glitch_no_valid", 32'(got_valid), 32'(v0));
        check("glitch_no_ferr", 32'(fe_cnt), 32'(f0));
        check("glitch_message", 32'(message), 32'(model_msg));

        // Bad stop bit followed by a held break, then a clean frame
        v0 = got_valid; f0 = fe_cnt;
        send_frame(8'h5A, 1'b0, 1'b0);
        hold(1'b0, 100);
        hold(1'b1, 20);
        check("break_one_ferr", 32'(fe_cnt), 32'(f0 + 1));
        check("break_no_valid", 32'(got_valid), 32'(v0));
        check("break_message_held", 32'(message), 32'(model_msg));
        check("break_busy_low", 32'(busy), 32'd0);
        exp_q.push_back(8'h81);
        send_frame(8'h81, 1'b1, 1'b0);
        drain("drain_81");
        hold(1'b1, 10);
        check("after_break_message", 32'(message), 32'h81);
        check("after_break_ferr", 32'(fe_cnt), 32'(f0 + 1));

        // Reset in the middle of data bit 4
        v0 = got_valid;
        d = 8'hC3;
        hold(1'b0, CPB);
        for (int k = 0; k < 4; k++) hold(d[k], CPB);
        hold(d[4], CPB / 2);
        check("midframe_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        model_msg = '0;
        #1;
        check("rst_message", 32'(message), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_ferr", 32'(framing_error), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rx = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        hold(1'b1, 5);
        exp_q.push_back(8'h17);
        send_frame(8'h17, 1'b1, 1'b0);
        drain("drain_17");
        hold(1'b1, 10);
        check("rst_no_c3", 32'(got_valid), 32'(v0 + 1));
        check("after_rst_message", 32'(message), 32'h17);

        // Edge timing jitter
        exp_q.push_back(8'h96);
        send_frame(8'h96, 1'b1, 1'b1);
        drain("drain_96");
        hold(1'b1, 5);
        check("jitter_message", 32'(message), 32'h96);

        // Random words, random gaps, random jitter
        f0 = fe_cnt;
        for (int n = 0; n < 24; n++) begin
            d = NB'($urandom);
            exp_q.push_back(d);
            send_frame(d, 1'b1, bit'($urandom_range(0, 1)));
            hold(1'b1, int'($urandom_range(0, 6)));
        end
        drain("drain_random");
        hold(1'b1, 10);
        check("random_no_ferr", 32'(fe_cnt), 32'(f0));
        check("random_last_message", 32'(message), 32'(model_msg));
        check("random_busy_low", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
